// File: rtl/addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : addr_gen
//  Description : 6502-style address generator. Selects a base (zero, AB, PC
//                or {DB,DR}), adds an offset (+0, +1, +IDX, -1), drives the
//                unregistered next address on AD and registers it onto AB.
//                It also maintains the program counter PC and the data latch
//                DR.
//  Ports       : clk, reset (sync, active-high), rdy, halt (state enables),
//                op[3:0] (base/offset select), DB, IDX (8-bit operands),
//                ld_pc, inc_pc (PC load control),
//                AB, AD, PC (AW-bit addresses), busy, pcross (status).
//  Config      : `define PAGE_FIX_EN adds the FIX state. Indexed adds that
//                cross a page then take one extra cycle to fix the high byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module addr_gen #(
    parameter int              AW        = 16,
    parameter logic [AW-1:0]   RESET_VEC = AW'(16'hFFFC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rdy,
    input  logic          halt,
    input  logic [3:0]    op,
    input  logic [7:0]    DB,
    input  logic [7:0]    IDX,
    input  logic          ld_pc,
    input  logic          inc_pc,
    output logic [AW-1:0] AB,
    output logic [AW-1:0] AD,
    output logic [AW-1:0] PC,
    output logic          busy,
    output logic          pcross
);

    localparam logic [AW-1:0] c_PAGE_STEP = AW'(9'h100);

    logic [AW-1:0] r_ab;
    logic [AW-1:0] r_pc;
    logic [7:0]    r_dr;

    logic          w_en;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_off;
    logic [AW-1:0] w_sum;
    logic          w_carry8;

    assign w_en = rdy & ~halt;

    always_comb begin
        w_base = '0;
        case (op[3:2])
            2'b00:   w_base = '0;
            2'b01:   w_base = r_ab;
            2'b10:   w_base = r_pc;
            default: w_base = AW'({DB, r_dr});
        endcase
    end

    always_comb begin
        w_off = '0;
        case (op[1:0])
            2'b00:   w_off = '0;
            2'b01:   w_off = AW'(1'b1);
            2'b10:   w_off = AW'(IDX);
            default: w_off = '1;
        endcase
    end

    assign w_sum = w_base + w_off;

    // Carry into bit 8 recovered from the full-width sum: sum ^ a ^ b at bit 8.
    assign w_carry8 = w_sum[8] ^ w_base[8] ^ w_off[8];

    // For -1 the interesting event is a borrow out of the low byte, which
    // happens exactly when the low byte was zero.
    always_comb begin
        pcross = 1'b0;
        case (op[1:0])
            2'b00:   pcross = 1'b0;
            2'b11:   pcross = (w_base[7:0] == 8'h00);
            default: pcross = w_carry8;
        endcase
    end

    assign AB = r_ab;
    assign PC = r_pc;

`ifdef PAGE_FIX_EN
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_FIX  = 1'b1;

    logic [0:0] r_state;
    logic       w_fix;
    logic       w_page_fix;

    assign w_fix      = (r_state == c_FIX);
    assign w_page_fix = (op[1:0] == 2'b10) & pcross;
    assign busy       = w_fix;
    assign AD         = w_fix ? (r_ab + c_PAGE_STEP) : w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ab    <= RESET_VEC;
            r_pc    <= '0;
            r_dr    <= '0;
            r_state <= c_IDLE;
        end else if (w_en) begin
            r_dr <= DB;
            if (ld_pc && !w_fix) begin
                r_pc <= r_ab + AW'(inc_pc);
            end
            case (r_state)
                c_IDLE: begin
                    if (w_page_fix) begin
                        // Emit the uncorrected page first, fix the high byte next cycle.
                        r_ab    <= {w_base[AW-1:8], w_sum[7:0]};
                        r_state <= c_FIX;
                    end else begin
                        r_ab    <= w_sum;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_ab    <= r_ab + c_PAGE_STEP;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end
`else
    assign busy = 1'b0;
    assign AD   = w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ab <= RESET_VEC;
            r_pc <= '0;
            r_dr <= '0;
        end else if (w_en) begin
            r_dr <= DB;
            r_ab <= w_sum;
            if (ld_pc) begin
                r_pc <= r_ab + AW'(inc_pc);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addr_gen
//  Description : Directed self-checking bench for addr_gen (AW=16). Follows
//                the PAGE_FIX_EN build setting for page-cross expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_gen;

    logic        clk = 1'b0;
    logic        reset, rdy, halt, ld_pc, inc_pc;
    logic [3:0]  op;
    logic [7:0]  DB, IDX;
    logic [15:0] AB, AD, PC;
    logic        busy, pcross;

    int n_cmp = 0;
    int n_err = 0;

    addr_gen #(.AW(16)) dut (
        .clk(clk), .reset(reset), .rdy(rdy), .halt(halt), .op(op),
        .DB(DB), .IDX(IDX), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .AB(AB), .AD(AD), .PC(PC), .busy(busy), .pcross(pcross)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rdy = 1'b0; halt = 1'b1; op = 4'b0000;
        DB = 8'h00; IDX = 8'h00; ld_pc = 1'b0; inc_pc = 1'b0;
        step();
        n_cmp++; if (AB !== 16'hFFFC) begin n_err++; $display("FAIL reset_ab: got %h want FFFC", AB); end
        n_cmp++; if (PC !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h want 0000", PC); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (AD !== 16'h0000) begin n_err++; $display("FAIL reset_ad: got %h want 0000", AD); end
        reset = 1'b0; rdy = 1'b1; halt = 1'b0;
    endtask

    task automatic test_pc_load();
        DB = 8'hFF; op = 4'b0000; step();           // DR=FF, AB=0
        DB = 8'h12; op = 4'b1100; step();           // AB={12,FF}
        n_cmp++; if (AB !== 16'h12FF) begin n_err++; $display("FAIL ab_dbdr: got %h want 12FF", AB); end
        op = 4'b0100; ld_pc = 1'b1; inc_pc = 1'b0; step();
        n_cmp++; if (PC !== 16'h12FF) begin n_err++; $display("FAIL pc_load: got %h want 12FF", PC); end
        inc_pc = 1'b1; step();
        n_cmp++; if (PC !== 16'h1300) begin n_err++; $display("FAIL pc_inc: got %h want 1300", PC); end
        ld_pc = 1'b0; inc_pc = 1'b0; op = 4'b0011; step();
        n_cmp++; if (AB !== 16'hFFFF) begin n_err++; $display("FAIL ab_minus1: got %h want FFFF", AB); end
        n_cmp++; if (pcross !== 1'b1) begin n_err++; $display("FAIL pcross_borrow0: got %b want 1", pcross); end
        op = 4'b0100; ld_pc = 1'b1; inc_pc = 1'b1; step();
        n_cmp++; if (PC !== 16'h0000) begin n_err++; $display("FAIL pc_wrap: got %h want 0000", PC); end
        ld_pc = 1'b0; inc_pc = 1'b0;
    endtask

    task automatic enter_cross();
        DB = 8'hF0; op = 4'b0000; step();           // DR=F0
        DB = 8'h20; IDX = 8'h20; op = 4'b1110; #1;
    endtask

    task automatic test_page_cross();
        enter_cross();
        n_cmp++; if (pcross !== 1'b1) begin n_err++; $display("FAIL pcross_idx: got %b want 1", pcross); end
        n_cmp++; if (AD !== 16'h2110) begin n_err++; $display("FAIL ad_idx: got %h want 2110", AD); end
        step();
`ifdef PAGE_FIX_EN
        n_cmp++; if (AB !== 16'h2010) begin n_err++; $display("FAIL fix_ab: got %h want 2010", AB); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fix_busy: got %b want 1", busy); end
        n_cmp++; if (AD !== 16'h2110) begin n_err++; $display("FAIL fix_ad: got %h want 2110", AD); end
        op = 4'b0000; ld_pc = 1'b1; step();
        n_cmp++; if (AB !== 16'h2110) begin n_err++; $display("FAIL fix_done_ab: got %h want 2110", AB); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fix_done_busy: got %b want 0", busy); end
        n_cmp++; if (PC !== 16'h0000) begin n_err++; $display("FAIL fix_pc_held: got %h want 0000", PC); end
`else
        n_cmp++; if (AB !== 16'h2110) begin n_err++; $display("FAIL nofix_ab: got %h want 2110", AB); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nofix_busy: got %b want 0", busy); end
        op = 4'b0000; ld_pc = 1'b1; step();
        n_cmp++; if (AB !== 16'h0000) begin n_err++; $display("FAIL nofix_ab2: got %h want 0000", AB); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nofix_busy2: got %b want 0", busy); end
        n_cmp++; if (PC !== 16'h2110) begin n_err++; $display("FAIL nofix_pc: got %h want 2110", PC); end
`endif
        ld_pc = 1'b0;
    endtask

    task automatic test_freeze();
        logic [15:0] pc_exp;
`ifdef PAGE_FIX_EN
        pc_exp = 16'h0000;
`else
        pc_exp = 16'h2110;
`endif
        DB = 8'h34; op = 4'b0000; step();           // DR=34, AB=0
        rdy = 1'b0; DB = 8'h56; op = 4'b1101; ld_pc = 1'b1; inc_pc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (AB !== 16'h0000 || PC !== pc_exp) begin n_err++; $display("FAIL rdy_hold[%0d]: AB=%h PC=%h want 0000/%h", i, AB, PC, pc_exp); end
            n_cmp++; if (AD !== 16'h5635) begin n_err++; $display("FAIL rdy_dr_hold[%0d]: AD=%h want 5635", i, AD); end
        end
        rdy = 1'b1; halt = 1'b1; step();
        n_cmp++; if (AB !== 16'h0000 || PC !== pc_exp) begin n_err++; $display("FAIL halt_hold: AB=%h PC=%h want 0000/%h", AB, PC, pc_exp); end
        halt = 1'b0; step();
        n_cmp++; if (AB !== 16'h5635) begin n_err++; $display("FAIL release_ab: got %h want 5635", AB); end
        n_cmp++; if (PC !== 16'h0001) begin n_err++; $display("FAIL release_pc: got %h want 0001", PC); end
        ld_pc = 1'b0; inc_pc = 1'b0;
`ifdef PAGE_FIX_EN
        enter_cross(); step();
        rdy = 1'b0; op = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (AB !== 16'h2010 || busy !== 1'b1) begin n_err++; $display("FAIL fix_rdy_hold[%0d]: AB=%h busy=%b want 2010/1", i, AB, busy); end
        end
        rdy = 1'b1; step();
        n_cmp++; if (AB !== 16'h2110 || busy !== 1'b0) begin n_err++; $display("FAIL fix_resume: AB=%h busy=%b want 2110/0", AB, busy); end
        enter_cross(); step();
        reset = 1'b1; step(); reset = 1'b0;
        n_cmp++; if (AB !== 16'hFFFC || busy !== 1'b0) begin n_err++; $display("FAIL fix_reset: AB=%h busy=%b want FFFC/0", AB, busy); end
`endif
    endtask

    task automatic test_decrement();
        DB = 8'h00; op = 4'b0000; step();           // DR=00
        DB = 8'h34; op = 4'b1100; step();           // AB=3400
        n_cmp++; if (AB !== 16'h3400) begin n_err++; $display("FAIL dec_setup: got %h want 3400", AB); end
        op = 4'b0111; #1;
        n_cmp++; if (pcross !== 1'b1) begin n_err++; $display("FAIL dec_pcross: got %b want 1", pcross); end
        n_cmp++; if (AD !== 16'h33FF) begin n_err++; $display("FAIL dec_ad: got %h want 33FF", AD); end
        step();
        n_cmp++; if (AB !== 16'h33FF || busy !== 1'b0) begin n_err++; $display("FAIL dec_ab: AB=%h busy=%b want 33FF/0", AB, busy); end
        n_cmp++; if (pcross !== 1'b0) begin n_err++; $display("FAIL dec_nocross: got %b want 0", pcross); end
        op = 4'b0101; #1;
        n_cmp++; if (pcross !== 1'b1 || AD !== 16'h3400) begin n_err++; $display("FAIL inc_cross: pcross=%b AD=%h want 1/3400", pcross, AD); end
        step();
        n_cmp++; if (AB !== 16'h3400 || busy !== 1'b0) begin n_err++; $display("FAIL inc_ab: AB=%h busy=%b want 3400/0", AB, busy); end
        op = 4'b0100; #1;
        n_cmp++; if (pcross !== 1'b0 || AD !== 16'h3400) begin n_err++; $display("FAIL plus0: pcross=%b AD=%h want 0/3400", pcross, AD); end
    endtask

    initial begin
        test_reset();
        test_pc_load();
        test_page_cross();
        test_freeze();
        test_decrement();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addr_gen.md
ADDR_GEN -- requirements
Module: addr_gen

Interface
REQ-001 Parameter AW, default 16: address width, legal range 16..24.
REQ-002 Parameter RESET_VEC, default 16'hFFFC zero-extended to AW: AB value loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 rdy  input  1  bus ready; low freezes all state.
REQ-006 halt  input  1  halt request; high freezes all state.
REQ-007 op  input  4  op[3:2] base select, op[1:0] offset select.
REQ-008 DB  input  8  data bus.
REQ-009 IDX  input  8  index register value, zero-extended.
REQ-010 ld_pc  input  1  load PC from AB.
REQ-011 inc_pc  input  1  add 1 during PC load.
REQ-012 AB  output  AW  registered address bus.
REQ-013 AD  output  AW  unregistered next-address value.
REQ-014 PC  output  AW  program counter.
REQ-015 busy  output  1  page-fix cycle in progress; upstream sequencer holds op.
REQ-016 pcross  output  1  combinational: current add carried out of bit 7.

Function
REQ-017 Internal DR[7:0] SHALL capture DB on every enabled edge (rdy & ~halt).
REQ-018 Base: op[3:2]=00 zero, 01 AB, 10 PC, 11 {DB,DR} (DB bits 15:8, DR bits 7:0, upper bits zero).
REQ-019 Offset: op[1:0]=00 +0, 01 +1, 10 +IDX, 11 -1 (all-ones); sum modulo 2^AW.
REQ-020 pcross SHALL equal carry out of base[7:0] + offset[7:0] for offsets +1 and +IDX; 0 for +0; for -1, 1 when base[7:0]=00 (borrow).
REQ-021 States IDLE, FIX; busy = (state==FIX).
REQ-022 IDLE, enabled edge: AB <= AD; stay IDLE unless REQ-030 applies.
REQ-023 FIX, enabled edge: AB <= AB + 2^8 (modulo 2^AW); op ignored; next state IDLE; AD = AB + 2^8 while in FIX.
REQ-024 rdy low or halt high: AB, PC, DR, state all hold; AD, pcross stay combinational.
REQ-025 PC <= AB + inc_pc (modulo 2^AW) on enabled edge when ld_pc=1 and busy=0; ld_pc during FIX ignored.
REQ-026 PC wrap: all-ones + 1 SHALL give 0.
REQ-027 AB and PC SHALL never change without an enabled edge or reset.

Reset
REQ-028 reset SHALL take priority over rdy, halt and all other inputs.
REQ-029 On reset edge: AB=RESET_VEC, PC=0, DR=0, state=IDLE (busy=0); reset during FIX abandons the fix.

Configuration
REQ-030 Macro PAGE_FIX_EN defined: for op[1:0]=10 with pcross=1, IDLE edge loads AB with base[AW-1:8] unchanged and low byte = sum[7:0], then enters FIX (one extra cycle, 6502 page-cross penalty).
REQ-031 Macro PAGE_FIX_EN undefined: FIX state absent, busy tied 0, every add is full AW-bit single-cycle; pcross still reported.

Verification
REQ-032 reset=1 with rdy=0, halt=1 -> next edge AB=16'hFFFC, PC=0, busy=0.
REQ-033 PC=16'h12FF, ld_pc=1 with AB=16'h12FF, inc_pc=1 -> PC=16'h1300; AB=16'hFFFF, inc_pc=1 -> PC=0.
REQ-034 PAGE_FIX_EN, DR=8'hF0, DB=8'h20, IDX=8'h20, op=4'b1110 -> pcross=1, AB=16'h2010, busy=1 one cycle, then AB=16'h2110, busy=0; ld_pc during busy leaves PC unchanged.
REQ-035 PAGE_FIX_EN undefined, same stimulus -> AB=16'h2110 in one cycle, busy=0 throughout.
REQ-036 In FIX, rdy=0 for 3 cycles -> AB=16'h2010 and busy=1 held; rdy=1 -> AB=16'h2110; reset asserted in FIX instead -> AB=16'hFFFC, busy=0.
REQ-037 AB=16'h3400, op=4'b0111 -> pcross=1, AD=16'h33FF, AB=16'h33FF with no FIX cycle.
